// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checked byte stream and writes it into
// instruction memory. It holds the core in reset until the load is verified.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [2:0] S_LEN_LO  = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam logic [ADDR_WIDTH:0] IDX_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [31:0]         CAPACITY = 32'd1 << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           asm_q, asm_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  handshake;
  logic [15:0]           len_full;
  logic [ADDR_WIDTH:0]   idx_next;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign rx_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign handshake  = rx_valid && rx_ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = word_idx_q;
  assign load_done  = (state_q == S_DONE);
  assign load_error = (state_q == S_ERROR);
  assign core_reset = !(state_q == S_DONE);

  // Next-state, word assembly, checksum and write-strobe generation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_full   = {rx_data, len_q[7:0]};
    idx_next   = word_idx_q + IDX_ONE;
    case (state_q)
      S_LEN_LO: begin
        if (handshake) begin
          len_d   = {8'd0, rx_data};
          state_d = S_LEN_HI;
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (handshake) begin
          len_d = len_full;
          if ({16'd0, len_full} > CAPACITY) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_PAYLOAD: begin
        if (handshake) begin
          // First byte of a word ends up in bits 7:0 after four right shifts
          asm_d      = {rx_data, asm_q[31:8]};
          csum_d     = csum_update(csum_q, rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q[ADDR_WIDTH-1:0];
            wdata_d    = asm_d;
            word_idx_d = idx_next;
            if (32'(idx_next) == {16'd0, len_q}) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_PAYLOAD;
            end
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CHECK: begin
        if (handshake) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN_LO;
      len_q      <= 16'd0;
      asm_q      <= 32'd0;
      byte_cnt_q <= 2'd0;
      csum_q     <= 8'd0;
      word_idx_q <= {(ADDR_WIDTH+1){1'b0}};
      we_q       <= 1'b0;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams are checked against a reference
// model that decodes the stream format directly from the byte list.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int          w_addr[$];
  logic [31:0] w_data[$];
  int          w_wc[$];
  int          w_cyc[$];
  int          acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (imem_we) begin
      w_addr.push_back(int'(imem_addr));
      w_data.push_back(imem_wdata);
      w_wc.push_back(int'(word_count));
      w_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    w_addr.delete(); w_data.delete(); w_wc.delete(); w_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    check_eq({nm, ".rst_ready"}, 32'(rx_ready), 32'd1);
    check_eq({nm, ".rst_we"}, 32'(imem_we), 32'd0);
    check_eq({nm, ".rst_addr"}, 32'(imem_addr), 32'd0);
    check_eq({nm, ".rst_wdata"}, imem_wdata, 32'd0);
    check_eq({nm, ".rst_core_reset"}, 32'(core_reset), 32'd1);
    check_eq({nm, ".rst_flags"}, {30'd0, load_done, load_error}, 32'd0);
    check_eq({nm, ".rst_wc"}, 32'(word_count), 32'd0);
  endtask

  // Offer one byte after a gap; give up if not taken within 8 cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    for (int t = 0; t < 8 && !acc; t++) begin
      if (rx_ready) begin
        acc = 1'b1;
        acc_cyc.push_back(cyc);
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] s[$], input int gmax);
    foreach (s[i]) send_byte(s[i], $urandom_range(gmax, 0));
  endtask

  task automatic check_result(input logic [7:0] s[$], input string nm);
    int n, exp_acc, exp_wr, base;
    bit too_big, ok;
    logic [7:0] x;
    logic [31:0] wd;
    n = int'(s[0]) | (int'(s[1]) << 8);
    too_big = (n > (1 << AW));
    x = 8'd0;
    ok = 1'b0;
    if (!too_big) begin
      for (int k = 0; k < 4 * n; k++) x ^= s[2 + k];
      ok = (s[2 + 4 * n] == x);
    end
    exp_acc = too_big ? 2 : 3 + 4 * n;
    exp_wr  = too_big ? 0 : n;
    check_eq({nm, ".accepted"}, 32'(acc_cyc.size()), 32'(exp_acc));
    check_eq({nm, ".writes"}, 32'(w_data.size()), 32'(exp_wr));
    for (int k = 0; k < exp_wr && k < w_data.size(); k++) begin
      base = 2 + 4 * k;
      wd = {s[base + 3], s[base + 2], s[base + 1], s[base]};
      check_eq($sformatf("%s.addr%0d", nm, k), 32'(w_addr[k]), 32'(k));
      check_eq($sformatf("%s.data%0d", nm, k), w_data[k], wd);
      check_eq($sformatf("%s.wc%0d", nm, k), 32'(w_wc[k]), 32'(k + 1));
      if (base + 3 < acc_cyc.size())
        check_eq($sformatf("%s.lat%0d", nm, k), 32'(w_cyc[k]), 32'(acc_cyc[base + 3] + 1));
    end
    check_eq({nm, ".done"}, 32'(load_done), 32'(ok));
    check_eq({nm, ".error"}, 32'(load_error), 32'(!ok));
    check_eq({nm, ".core_reset"}, 32'(core_reset), 32'(!ok));
    check_eq({nm, ".ready"}, 32'(rx_ready), 32'd0);
    check_eq({nm, ".word_count"}, 32'(word_count), 32'(exp_wr));
    if (exp_wr > 0 && w_data.size() == exp_wr) begin
      check_eq({nm, ".hold_addr"}, 32'(imem_addr), 32'(exp_wr - 1));
      check_eq({nm, ".hold_data"}, imem_wdata, w_data[exp_wr - 1]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base_s[$];
    logic [7:0] s[$];
    logic [7:0] x;
    int n;

    base_s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};

    // Two-word good load, then an extra byte must be refused
    do_reset("good");
    send_list(base_s, 0);
    check_eq("good.core_reset_next", 32'(core_reset), 32'd0);
    send_byte(8'h55, 0);
    check_result(base_s, "good");
    if (w_data.size() == 2) begin
      check_eq("good.w0", w_data[0], 32'h00500093);
      check_eq("good.w1", w_data[1], 32'h00A00113);
    end

    s = base_s; s[10] = 8'h70;
    do_reset("badck");
    send_list(s, 0);
    check_result(s, "badck");

    s = '{8'h00, 8'h00, 8'h00};
    do_reset("empty");
    send_list(s, 0);
    check_result(s, "empty");

    s = '{8'h01, 8'h01};
    do_reset("big");
    send_list(s, 0);
    check_eq("big.error_next", 32'(load_error), 32'd1);
    send_list('{8'h11, 8'h22, 8'h33}, 0);
    check_result(s, "big");

    do_reset("gaps");
    send_list(base_s, 5);
    check_result(base_s, "gaps");

    // Abort after three payload bytes; reset coincides with an offered byte
    do_reset("midrst");
    send_list('{8'h02, 8'h00, 8'h93, 8'h00, 8'h50}, 0);
    check_eq("midrst.no_write", 32'(w_data.size()), 32'd0);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0;
    check_eq("midrst.wc", 32'(word_count), 32'd0);
    check_eq("midrst.no_write2", 32'(w_data.size()), 32'd0);
    clear_mon();
    send_list(base_s, 0);
    check_result(base_s, "midrst");

    for (int it = 0; it < 10; it++) begin
      s.delete();
      if ($urandom_range(5, 0) == 0) begin
        n = $urandom_range(700, 257);
        s.push_back(8'(n)); s.push_back(8'(n >> 8));
        s.push_back(8'($urandom)); s.push_back(8'($urandom));
      end else begin
        n = $urandom_range(5, 0);
        s.push_back(8'(n)); s.push_back(8'd0);
        x = 8'd0;
        for (int k = 0; k < 4 * n; k++) begin
          s.push_back(8'($urandom));
          x ^= s[s.size() - 1];
        end
        if ($urandom_range(1, 0) == 1) s.push_back(x);
        else s.push_back(x ^ 8'($urandom_range(255, 1)));
      end
      do_reset($sformatf("rnd%0d", it));
      send_list(s, $urandom_range(3, 0));
      check_result(s, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
